// File: rtl/prm_obstacle_scan.sv
// ---------------------------------------------------------------------------
// prm_obstacle_scan
//
// Streams the obstacle/edge codes of one frame (one PRM edge query) into an
// external combinational collision checker and summarises the frame.
//
// Each accepted code is registered onto chk_code. The checker's edge mask is
// sampled in the following cycle. Per frame the block keeps three results:
// the number of evaluated obstacles, the number of hits, and a blocked flag.
// The result is held on res_* until the downstream side accepts it.
//
// Optional build macro: EARLY_EXIT_EN
//   When defined, the first hit ends the evaluation of the frame. The result
//   is presented immediately. Any codes of that frame still to arrive are
//   then accepted and discarded in the FLUSH state.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   obs_valid/ready  obstacle-code handshake
//   obs_code[14:0]   obstacle/edge vector (bit0 = A ... bit14 = O)
//   obs_last         marks the final code of the frame
//   chk_code[14:0]   registered vector driving checker inputs A..O
//   chk_mask         checker edge_mask for chk_code (combinational return)
//   res_valid/ready  frame-result handshake
//   res_blocked      at least one evaluated obstacle hit
//   res_hits         saturating hit count
//   res_obs          saturating evaluated-obstacle count
// ---------------------------------------------------------------------------
module prm_obstacle_scan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obs_valid,
  output logic             obs_ready,
  input  logic [14:0]      obs_code,
  input  logic             obs_last,
  output logic [14:0]      chk_code,
  input  logic             chk_mask,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_blocked,
  output logic [CNT_W-1:0] res_hits,
  output logic [CNT_W-1:0] res_obs
);

`ifdef EARLY_EXIT_EN
  typedef enum logic [1:0] {SCAN = 2'd0, RESULT = 2'd1, FLUSH = 2'd2} state_t;
`else
  typedef enum logic [0:0] {SCAN = 1'b0, RESULT = 1'b1} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             s1_valid;
  logic             s1_last;
  logic             blocked;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] obs_cnt;
  logic             accept;
  logic             frame_done;
`ifdef EARLY_EXIT_EN
  logic             exit_last;   // the sample that ended the frame also had obs_last
`endif

  // NOTE: every signal assigned in always_comb gets a default first. Without
  // the default, a path that leaves a signal unassigned infers a latch.
  always_comb begin
    obs_ready = 1'b0;
    if (rst_n) begin
      case (state)
        SCAN: begin
          // Stop taking codes once the frame's last code is waiting to be
          // sampled. This keeps the next frame out of the counters.
          obs_ready = !(s1_valid && s1_last);
`ifdef EARLY_EXIT_EN
          if (s1_valid && chk_mask) obs_ready = 1'b0;
`endif
        end
`ifdef EARLY_EXIT_EN
        FLUSH:   obs_ready = 1'b1;
`endif
        default: obs_ready = 1'b0;
      endcase
    end
  end

  assign accept = obs_valid && obs_ready;

  always_comb begin
    frame_done = s1_valid && s1_last;
`ifdef EARLY_EXIT_EN
    if (s1_valid && chk_mask) frame_done = 1'b1;
`endif
  end

  // NOTE: state is updated with non-blocking assignments only. Every flop
  // then sees the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      chk_code  <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      blocked   <= 1'b0;
      hit_cnt   <= '0;
      obs_cnt   <= '0;
      res_valid <= 1'b0;
`ifdef EARLY_EXIT_EN
      exit_last <= 1'b0;
`endif
    end else begin
      s1_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (accept) begin
            chk_code <= obs_code;
            s1_valid <= 1'b1;
            s1_last  <= obs_last;
          end
          if (s1_valid) begin
            // Counters saturate. The blocked flag stays exact after saturation.
            if (obs_cnt != CNT_MAX) obs_cnt <= obs_cnt + CNT_ONE;
            if (chk_mask && hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_ONE;
            blocked <= blocked | chk_mask;
            if (frame_done) begin
              state     <= RESULT;
              res_valid <= 1'b1;
`ifdef EARLY_EXIT_EN
              exit_last <= s1_last;
`endif
            end
          end
        end
        RESULT: begin
          if (res_ready) begin
            obs_cnt   <= '0;
            hit_cnt   <= '0;
            blocked   <= 1'b0;
            res_valid <= 1'b0;
            state     <= SCAN;
`ifdef EARLY_EXIT_EN
            // The frame ended early on a hit. Its remaining codes still have
            // to be drained before the next frame starts.
            if (!exit_last) state <= FLUSH;
`endif
          end
        end
`ifdef EARLY_EXIT_EN
        FLUSH: begin
          if (accept && obs_last) state <= SCAN;
        end
`endif
        default: state <= SCAN;
      endcase
    end
  end

  assign res_blocked = blocked;
  assign res_hits    = hit_cnt;
  assign res_obs     = obs_cnt;

endmodule

// File: doc/prm_obstacle_scan.md
PRM_OBSTACLE_SCAN -- requirements
Module: prm_obstacle_scan

Interface
REQ-001 Parameter CNT_W, default 8: width of the per-frame obstacle and hit counters.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RST_N  input  1  asynchronous reset, active low.
REQ-004 obs_valid  input  1  upstream obstacle-code valid.
REQ-005 obs_ready  output  1  block accepts obs_code this cycle.
REQ-006 obs_code  input  15  encoded obstacle/edge vector; bit0=A ... bit14=O.
REQ-007 obs_last  input  1  final obstacle of the current frame (one frame = one edge query).
REQ-008 chk_code  output  15  registered vector driving the checker inputs A..O (bit0=A).
REQ-009 chk_mask  input  1  combinational edge_mask returned by the checker for chk_code.
REQ-010 res_valid  output  1  frame result valid.
REQ-011 res_ready  input  1  downstream accepts the result.
REQ-012 res_blocked  output  1  1 = at least one obstacle in the frame produced chk_mask=1.
REQ-013 res_hits  output  CNT_W  number of evaluated obstacles with chk_mask=1, saturating.
REQ-014 res_obs  output  CNT_W  number of evaluated obstacles in the frame, saturating.

Function
REQ-015 States: SCAN, RESULT and FLUSH (FLUSH only with EARLY_EXIT_EN).
REQ-016 Accept = obs_valid && obs_ready; on accept, chk_code <= obs_code, s1_valid <= 1, s1_last <= obs_last.
REQ-017 With no accept in a cycle, s1_valid <= 0 and chk_code holds its value.
REQ-018 When s1_valid=1 at an edge, chk_mask is sampled: obs count +1; hit count +1 if chk_mask=1; blocked |= chk_mask.
REQ-019 Both counters saturate at 2^CNT_W-1, never wrap, and keep counting correctly for blocked.
REQ-020 obs_ready = (state==SCAN) && !(s1_valid && s1_last); throughput is one obstacle per cycle.
REQ-021 Frame latency: obs_last accepted at edge t -> sampled at t+1 -> res_valid=1 from t+1 until handshake.
REQ-022 SCAN->RESULT at the edge that samples s1_last=1.
REQ-023 In RESULT, obs_ready=0, and res_* stay stable while res_valid && !res_ready.
REQ-024 At the res_valid && res_ready edge, the counters and blocked clear, s1_valid=0 and state -> SCAN.
REQ-025 A single-obstacle frame (obs_last on the first code) is legal; a frame with zero obstacles is not possible.
REQ-026 res_valid is never asserted in SCAN or FLUSH.

Reset
REQ-027 RST_N low clears asynchronously: state=SCAN, chk_code=0, s1_valid=0, s1_last=0, counters=0, blocked=0, res_valid=0.
REQ-028 Reset asserted mid-frame or in RESULT discards the partial frame; no result is emitted for it.
REQ-029 obs_ready is 0 while RST_N is low and becomes 1 in the first cycle after release.

Configuration
REQ-030 Macro EARLY_EXIT_EN compiled in: obs_ready is additionally 0 when s1_valid && chk_mask, and a sample with chk_mask=1 moves SCAN->RESULT immediately.
REQ-031 EARLY_EXIT_EN, after an early-exit handshake: if the hit sample had s1_last=1, go to SCAN; otherwise go to FLUSH.
REQ-032 EARLY_EXIT_EN, FLUSH state: obs_ready=1, accepted codes are discarded (chk_code unchanged, nothing counted), and accepting obs_last moves to SCAN.
REQ-033 Macro absent: every obstacle is evaluated, FLUSH does not exist, and res_hits is the full-frame count.

Verification
REQ-034 Checker stub drives chk_mask=0; frame of 3 codes 0x0001, 0x0002, 0x4003 (last) -> res_valid at cycle 4, blocked=0, hits=0, obs=3.
REQ-035 Mask pattern 0,1,0,1 over a 4-code frame, macro off -> blocked=1, hits=2, obs=4; obs_ready low from the last sample until handshake.
REQ-036 Same frame with EARLY_EXIT_EN -> result after the 2nd code with hits=1, obs=2; after handshake, the 2 remaining codes are flushed, then the next frame scans normally.
REQ-037 res_ready held low 5 cycles -> res_* constant; the next frame's first code is accepted only on the cycle after the handshake.
REQ-038 300 obstacles all hit, CNT_W=8 -> hits=255, obs=255, blocked=1.
REQ-039 RST_N pulsed low mid-frame after 2 codes -> all outputs at reset values, and a following 1-code frame gives obs=1.
